// File: rtl/isqrt_arb_pkg.sv
// Shared types and round-robin pick helper for the isqrt request arbiter.
// Optional ISQRT_ARB_PERF_EN adds perf counters in isqrt_rr_arbiter.
package isqrt_arb_pkg;

  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;
  localparam int RR_MAX    = 16;

  typedef logic [ISQRT_X_W-1:0] isqrt_x_t;
  typedef logic [ISQRT_Y_W-1:0] isqrt_y_t;

  // Unused request bits must be zero so a mod-16 search equals mod-N.
  function automatic logic [3:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [3:0]        ptr
  );
    logic [3:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order tag FIFO with same-cycle push/pop and empty bypass on head.
// Head shows din while empty so a push/pop in one cycle passes through.
module isqrt_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = empty ? din : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one in-order isqrt unit among N_REQ requesters.
// Define ISQRT_ARB_PERF_EN for perf_busy/perf_stall counters.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*32-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     rsp_vld,
  output isqrt_y_t             rsp_y,
  output logic                 isqrt_x_vld,
  output isqrt_x_t             isqrt_x,
  input  logic                 isqrt_y_vld,
  input  isqrt_y_t             isqrt_y,
`ifdef ISQRT_ARB_PERF_EN
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall,
`endif
  output logic                 err_orphan
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [TW-1:0]     ptr;
  logic [TW-1:0]     g;
  logic [TW-1:0]     tag;
  logic [RR_MAX-1:0] req_ext;
  logic              any_req;
  logic              full;
  logic              empty;
  logic              can_issue;
  logic              pop;
  logic              orphan;

  assign req_ext = RR_MAX'(req_vld);
  assign g       = TW'(rr_pick(req_ext, 4'(ptr)));
  assign any_req = |req_vld;

  // Full implies non-empty, so a result always pops when full; when
  // empty, any request is pushed and the result pairs with it.
  assign can_issue = any_req & (~full | isqrt_y_vld);
  assign pop       = isqrt_y_vld & (~empty | any_req);
  assign orphan    = isqrt_y_vld & empty & ~any_req;

  assign req_rdy     = can_issue ? (N_REQ'(1) << g) : '0;
  assign isqrt_x_vld = can_issue;
  assign isqrt_x     = can_issue ? req_x[ISQRT_X_W*int'(g) +: ISQRT_X_W]
                                 : 'x;

  isqrt_tag_fifo #(
    .W     (TW),
    .DEPTH (MAX_OUT)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (can_issue),
    .pop   (pop),
    .din   (g),
    .full  (full),
    .empty (empty),
    .head  (tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (can_issue) begin
      ptr <= (g == TW'(N_REQ-1)) ? '0 : g + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld    <= '0;
      rsp_y      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_vld <= pop ? (N_REQ'(1) << tag) : '0;
      if (pop)    rsp_y      <= isqrt_y;
      if (orphan) err_orphan <= 1'b1;
    end
  end

`ifdef ISQRT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (!empty && perf_busy != '1)
        perf_busy <= perf_busy + 1'b1;
      if (any_req && !can_issue && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
